// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared sm83 bus constants and OAM DMA state type
package sm83_pkg;

    localparam logic [15:0] REG_DMA  = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int          OAM_LEN  = 160;
    localparam logic [15:0] IO_BASE  = 16'hFF00;

    typedef enum logic {
        IDLE,
        XFER
    } dma_state_t;

endpackage

// File: rtl/sm83_oam_dma.sv
// rtl/sm83_oam_dma.sv - OAM DMA engine: FF46 decode, 160-byte page copy, CPU conflict flag
module sm83_oam_dma
    import sm83_pkg::*;
#(
    parameter int                WORD_SIZE = 8,
    parameter int                ADR_WIDTH = 16,
    parameter logic [ADR_WIDTH-1:0] REG_ADR = REG_DMA,
    parameter int                LENGTH    = OAM_LEN,
    parameter int                ECHO_MAP  = 1
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 mcyc,
    input  logic [ADR_WIDTH-1:0] cpu_adr,
    input  logic [WORD_SIZE-1:0] cpu_dout,
    input  logic                 cpu_wr,
    input  logic                 cpu_rd,
    output logic [WORD_SIZE-1:0] reg_dout,
    output logic                 reg_oe,
    output logic [ADR_WIDTH-1:0] dma_adr,
    output logic                 dma_rd,
    input  logic [WORD_SIZE-1:0] ext_din,
    output logic [WORD_SIZE-1:0] oam_adr,
    output logic [WORD_SIZE-1:0] oam_dout,
    output logic                 oam_we,
    output logic                 active,
    output logic                 cpu_blk
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t           state;
    logic                 arm;
    logic [WORD_SIZE-1:0] reg_page;
    logic [WORD_SIZE-1:0] src_page;
    logic [7:0]           idx;
    logic [7:0]           oam_idx;
    logic [WORD_SIZE-1:0] data_q;
    logic                 wpend;
    logic                 reg_hit;
    logic                 reg_wr;

    // Echo RAM (E000h-FDFFh) mirrors C000h-DDFFh, so fold bit 5 of high pages.
    function automatic logic [WORD_SIZE-1:0] map_page(input logic [WORD_SIZE-1:0] p);
        if (ECHO_MAP != 0 && p >= WORD_SIZE'('hE0))
            return p & ~WORD_SIZE'('h20);
        return p;
    endfunction

    assign reg_hit = (cpu_adr == REG_ADR);
    assign reg_wr  = cpu_wr && reg_hit;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            arm      <= 1'b0;
            reg_page <= '0;
            src_page <= '0;
            idx      <= '0;
            oam_idx  <= '0;
            data_q   <= '0;
            wpend    <= 1'b0;
        end else if (mcyc) begin
            if (state == XFER) begin
                data_q  <= ext_din;
                oam_idx <= idx;
                wpend   <= 1'b1;
                if (idx == LAST_IDX)
                    state <= IDLE;
                else
                    idx <= idx + 8'd1;
            end else begin
                wpend <= 1'b0;
            end
            // The write M-cycle is followed by one startup M-cycle; a reload
            // at its end takes precedence over the running transfer's advance.
            if (reg_wr) begin
                reg_page <= cpu_dout;
                arm      <= 1'b1;
            end else if (arm) begin
                arm      <= 1'b0;
                src_page <= map_page(reg_page);
                idx      <= '0;
                state    <= XFER;
            end
        end
    end

    assign active   = (state == XFER);
    assign dma_rd   = active;
    assign dma_adr  = active ? ADR_WIDTH'({src_page, idx}) : '0;
    assign oam_we   = mcyc && wpend;
    assign oam_adr  = wpend ? WORD_SIZE'(oam_idx) : '0;
    assign oam_dout = wpend ? data_q : '0;
    assign reg_oe   = cpu_rd && reg_hit;
    assign reg_dout = reg_page;
    assign cpu_blk  = active && (cpu_rd || cpu_wr) && (cpu_adr < ADR_WIDTH'(IO_BASE));

endmodule

// File: tb/tb_sm83_oam_dma.sv
// tb/tb_sm83_oam_dma.sv - randomized self-checking bench for sm83_oam_dma
module tb_sm83_oam_dma;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        mcyc = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  ext_din = '0;

    logic [7:0]  reg_dout, reg_dout_r;
    logic        reg_oe, reg_oe_r;
    logic [15:0] dma_adr, dma_adr_r;
    logic        dma_rd, dma_rd_r;
    logic [7:0]  oam_adr, oam_adr_r, oam_dout, oam_dout_r;
    logic        oam_we, oam_we_r, active, active_r, cpu_blk, cpu_blk_r;

    sm83_oam_dma #(.ECHO_MAP(1)) u_dut (
        .clk(clk), .areset(areset), .mcyc(mcyc), .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .reg_dout(reg_dout), .reg_oe(reg_oe),
        .dma_adr(dma_adr), .dma_rd(dma_rd), .ext_din(ext_din), .oam_adr(oam_adr),
        .oam_dout(oam_dout), .oam_we(oam_we), .active(active), .cpu_blk(cpu_blk)
    );

    sm83_oam_dma #(.ECHO_MAP(0)) u_dut_raw (
        .clk(clk), .areset(areset), .mcyc(mcyc), .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .reg_dout(reg_dout_r), .reg_oe(reg_oe_r),
        .dma_adr(dma_adr_r), .dma_rd(dma_rd_r), .ext_din(ext_din), .oam_adr(oam_adr_r),
        .oam_dout(oam_dout_r), .oam_we(oam_we_r), .active(active_r), .cpu_blk(cpu_blk_r)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m = 0;
    int nw;

    // Model: each FF46 write schedules a transfer (raw page, first read M-cycle).
    // The newest transfer that has started owns the bus; OAM write = previous read.
    int         start_q[$];
    logic [7:0] page_q[$];
    logic [7:0] reg_model = '0;
    bit         prev_v = 1'b0;
    logic [7:0] prev_idx = '0;
    logic [7:0] prev_data = '0;
    bit         e_act;
    logic [7:0] e_page;
    logic [7:0] e_idx;

    localparam logic [15:0] ADR_TBL [8] = '{16'hFF46, 16'hC000, 16'hFF80, 16'h8000,
                                            16'hFE10, 16'hFF00, 16'hFEFF, 16'h0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (m=%0d)", name, act, exp, m);
        end
    endtask

    function automatic logic [7:0] echo(input logic [7:0] p);
        return (p >= 8'hE0) ? p - 8'h20 : p;
    endfunction

    task automatic model_eval();
        int best;
        best = -1;
        e_act = 1'b0;
        e_page = '0;
        e_idx = '0;
        foreach (start_q[i]) begin
            if (start_q[i] <= m && start_q[i] > best) begin
                best = start_q[i];
                e_page = page_q[i];
            end
        end
        if (best >= 0 && (m - best) < 160) begin
            e_act = 1'b1;
            e_idx = 8'(m - best);
        end
    endtask

    task automatic compare();
        logic blk;
        model_eval();
        blk = e_act && (cpu_rd || cpu_wr) && (cpu_adr < 16'hFF00);
        chk("active", active, e_act);
        chk("dma_rd", dma_rd, e_act);
        chk("dma_adr", dma_adr, e_act ? {echo(e_page), e_idx} : 16'h0);
        chk("dma_adr_raw", dma_adr_r, e_act ? {e_page, e_idx} : 16'h0);
        chk("oam_we", oam_we, prev_v);
        chk("oam_adr", oam_adr, prev_v ? prev_idx : 8'h0);
        chk("oam_dout", oam_dout, prev_v ? prev_data : 8'h0);
        chk("cpu_blk", cpu_blk, blk);
        chk("reg_oe", reg_oe, cpu_rd && cpu_adr == 16'hFF46);
        chk("reg_dout", reg_dout, reg_model);
    endtask

    task automatic mc_begin(input logic wr, input logic rd, input logic [15:0] adr, input logic [7:0] d);
        @(negedge clk);
        mcyc = 1'b0;
        cpu_wr = wr;
        cpu_rd = rd;
        cpu_adr = adr;
        cpu_dout = d;
        ext_din = 8'($urandom);
        repeat (3) @(negedge clk);
        mcyc = 1'b1;
        #1 compare();
    endtask

    task automatic mc_end();
        @(posedge clk);
        #1;
        if (cpu_wr && cpu_adr == 16'hFF46) begin
            reg_model = cpu_dout;
            for (int i = start_q.size() - 1; i >= 0; i--) begin
                if (start_q[i] > m) begin
                    start_q.delete(i);
                    page_q.delete(i);
                end
            end
            start_q.push_back(m + 2);
            page_q.push_back(cpu_dout);
        end
        prev_v = e_act;
        prev_idx = e_idx;
        prev_data = ext_din;
        m++;
    endtask

    task automatic mc(input logic wr, input logic rd, input logic [15:0] adr, input logic [7:0] d);
        mc_begin(wr, rd, adr, d);
        mc_end();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) mc(1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    initial begin
        #1;
        chk("rst_active", active, 1'b0);
        chk("rst_dma_adr", dma_adr, 16'h0);
        chk("rst_oam_we", oam_we, 1'b0);
        chk("rst_reg_dout", reg_dout, 8'h00);
        @(negedge clk);
        areset = 1'b0;
        idle(2);

        // Basic copy of page 40h
        mc(1'b1, 1'b0, 16'hFF46, 8'h40);
        nw = 0;
        for (int k = 1; k <= 163; k++) begin
            mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
            if (oam_we) nw++;
            if (k == 1) chk("basic_startup_idle", active, 1'b0);
            if (k == 2) chk("basic_first_adr", dma_adr, 16'h4000);
            if (k == 3) chk("basic_first_oam", {oam_we, oam_adr}, 9'h100);
            if (k == 161) chk("basic_last_adr", dma_adr, 16'h409F);
            if (k == 162) begin
                chk("basic_active_fell", active, 1'b0);
                chk("basic_last_oam", {oam_we, oam_adr}, 9'h19F);
            end
            mc_end();
        end
        chk("basic_write_count", nw, 160);

        // Echo mapping, then an unmapped page and CPU blocking during the copy
        mc(1'b1, 1'b0, 16'hFF46, 8'hE1);
        idle(1);
        mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
        chk("echo_mapped", dma_adr, 16'hC100);
        chk("echo_raw", dma_adr_r, 16'hE100);
        mc_end();
        mc(1'b1, 1'b0, 16'hFF46, 8'hDF);
        idle(1);
        mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
        chk("echo_df_unmapped", dma_adr, 16'hDF00);
        mc_end();
        mc_begin(1'b0, 1'b1, 16'hC000, 8'h0);
        chk("blk_rd_c000", cpu_blk, 1'b1);
        mc_end();
        mc_begin(1'b0, 1'b1, 16'hFF80, 8'h0);
        chk("blk_rd_ff80", cpu_blk, 1'b0);
        mc_end();
        mc_begin(1'b0, 1'b1, 16'hFF46, 8'h0);
        chk("reg_readback", {reg_oe, reg_dout}, 9'h1DF);
        mc_end();
        mc_begin(1'b1, 1'b0, 16'hFF46, 8'hDF);
        chk("blk_wr_ff46", cpu_blk, 1'b0);
        mc_end();
        idle(165);

        // Restart at idx 50h
        mc(1'b1, 1'b0, 16'hFF46, 8'h80);
        idle(1 + 8'h50);
        mc_begin(1'b1, 1'b0, 16'hFF46, 8'h90);
        chk("restart_at_50", dma_adr, 16'h8050);
        mc_end();
        mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
        chk("restart_continue_51", dma_adr, 16'h8051);
        mc_end();
        nw = 0;
        for (int k = 0; k < 170; k++) begin
            mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
            if (k == 0) chk("restart_new_page", dma_adr, 16'h9000);
            if (k > 0 && oam_we) nw++;
            mc_end();
        end
        chk("restart_write_count", nw, 160);

        // Back-to-back: write in the M-cycle reading idx 9Fh
        mc(1'b1, 1'b0, 16'hFF46, 8'h12);
        idle(160);
        mc_begin(1'b1, 1'b0, 16'hFF46, 8'h34);
        chk("b2b_old_last", dma_adr, 16'h129F);
        mc_end();
        mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
        chk("b2b_final_write", {active, oam_we, oam_adr}, 10'h19F);
        mc_end();
        mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
        chk("b2b_new_start", dma_adr, 16'h3400);
        mc_end();
        idle(165);

        // Asynchronous reset in the middle of a transfer
        mc(1'b1, 1'b0, 16'hFF46, 8'h56);
        idle(1 + 8'h20);
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        mcyc = 1'b0;
        #2 areset = 1'b1;
        #1;
        chk("rstmid_outputs", {active, dma_rd, dma_adr, oam_we, oam_adr, oam_dout, cpu_blk, reg_oe},
            32'h0);
        chk("rstmid_reg_dout", reg_dout, 8'h00);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        start_q.delete();
        page_q.delete();
        reg_model = '0;
        prev_v = 1'b0;
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            mc_begin(1'b0, 1'b0, 16'h0, 8'h0);
            if (oam_we) nw++;
            mc_end();
        end
        chk("rstmid_no_writes", nw, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [15:0] a;
            r = int'($urandom_range(0, 99));
            a = ADR_TBL[$urandom_range(0, 7)];
            if (r < 2)
                mc(1'b1, 1'b0, 16'hFF46, 8'($urandom));
            else if (r < 20)
                mc(1'b0, 1'b1, a, 8'h0);
            else if (r < 30)
                mc(1'b1, 1'b0, (a == 16'hFF46) ? 16'hFF47 : a, 8'($urandom));
            else
                mc(1'b0, 1'b0, 16'h0, 8'h0);
        end
        idle(170);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
